// File: rtl/dm_jtag_pkg.sv
// rtl/dm_jtag_pkg.sv - shared DTM/DMI types for the JTAG debug transport
package dm_jtag_pkg;

  localparam int unsigned DMI_ADDR_W = 7;
  localparam int unsigned DMI_DATA_W = 32;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'd0,
    DTM_READ  = 2'd1,
    DTM_WRITE = 2'd2
  } dtm_op_e;

  typedef enum logic [1:0] {
    DMINoError  = 2'd0,
    DMIOPFailed = 2'd2,
    DMIBusy     = 2'd3
  } dmi_error_e;

  typedef struct packed {
    logic [DMI_ADDR_W-1:0] addr;
    logic [1:0]            op;
    logic [DMI_DATA_W-1:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [DMI_DATA_W-1:0] data;
    logic                  err;
  } dmi_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT_READ,
    ST_WRITE,
    ST_WAIT_WRITE
  } dmi_state_e;

endpackage

// File: rtl/dmi_jtag_access_ctrl_if.sv
// rtl/dmi_jtag_access_ctrl_if.sv - DMI request/response handshake toward the debug module
interface dmi_jtag_access_ctrl_if #(
  parameter int unsigned AddrWidth = 7,
  parameter int unsigned DataWidth = 32
);

  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_op;
  logic [AddrWidth-1:0] req_addr;
  logic [DataWidth-1:0] req_data;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [DataWidth-1:0] resp_data;
  logic                 resp_err;

  modport master (
    output req_valid, req_op, req_addr, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/dmi_jtag_access_ctrl.sv
// rtl/dmi_jtag_access_ctrl.sv - DMI data register, access sequencer and sticky error for the DTM
module dmi_jtag_access_ctrl
  import dm_jtag_pkg::*;
#(
  parameter int unsigned AddrWidth = 7,
  parameter int unsigned DataWidth = 32
) (
  input  logic                  tck_i,
  input  logic                  trst_ni,
  input  logic                  test_logic_reset_i,
  input  logic                  dmi_access_i,
  input  logic                  capture_dr_i,
  input  logic                  shift_dr_i,
  input  logic                  update_dr_i,
  input  logic                  dmi_reset_i,
  input  logic                  dmi_tdi_i,
  output logic                  dmi_tdo_o,
  output logic [1:0]            dmi_error_o,
  dmi_jtag_access_ctrl_if.master dmi
);

  localparam int unsigned DrWidth = AddrWidth + DataWidth + 2;

  logic [DrWidth-1:0]   r_dr;
  logic [AddrWidth-1:0] r_addr;
  logic [DataWidth-1:0] r_data;
  logic [1:0]           r_error;
  dmi_state_e           r_state;
  logic                 r_req_valid;
  logic [1:0]           r_req_op;
  logic                 r_resp_ready;

  logic                 w_capture;
  logic                 w_shift;
  logic                 w_update;
  logic                 w_idle;
  logic                 w_in_wait;
  logic                 w_busy;
  logic                 w_fail;
  logic                 w_accept;
  logic [1:0]           w_err_next;
  logic [1:0]           w_dr_op;
  logic [DataWidth-1:0] w_dr_data;
  logic [AddrWidth-1:0] w_dr_addr;

  assign w_capture = dmi_access_i & capture_dr_i;
  assign w_shift   = dmi_access_i & shift_dr_i;
  assign w_update  = dmi_access_i & update_dr_i;
  assign w_idle    = (r_state == ST_IDLE);
  assign w_in_wait = (r_state == ST_WAIT_READ) || (r_state == ST_WAIT_WRITE);
  assign w_busy    = (w_capture | w_update) & ~w_idle;
  assign w_fail    = w_in_wait & dmi.resp_valid & dmi.resp_err;

  assign w_dr_op   = r_dr[1:0];
  assign w_dr_data = r_dr[DataWidth+1:2];
  assign w_dr_addr = r_dr[DrWidth-1:DataWidth+2];

  // A pending sticky error discards new requests; TLR blocks launching with freshly cleared fields.
  assign w_accept  = w_update & w_idle & (r_error == DMINoError) & ~test_logic_reset_i;

  // First error wins; dmireset overrides any same-cycle set.
  always_comb begin
    w_err_next = r_error;
    if (dmi_reset_i) begin
      w_err_next = DMINoError;
    end else if (r_error == DMINoError) begin
      if (w_busy) begin
        w_err_next = DMIBusy;
      end else if (w_fail) begin
        w_err_next = DMIOPFailed;
      end
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_dr    <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_error <= '0;
    end else if (test_logic_reset_i) begin
      r_dr    <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_error <= '0;
    end else begin
      r_error <= w_err_next;
      if (w_capture) begin
        r_dr <= {r_addr, r_data, w_err_next};
      end else if (w_shift) begin
        r_dr <= {dmi_tdi_i, r_dr[DrWidth-1:1]};
      end
      if (w_accept && (w_dr_op == DTM_READ || w_dr_op == DTM_WRITE)) begin
        r_addr <= w_dr_addr;
      end
      if (w_accept && w_dr_op == DTM_WRITE) begin
        r_data <= w_dr_data;
      end else if (r_state == ST_WAIT_READ && dmi.resp_valid) begin
        r_data <= dmi.resp_data;
      end
    end
  end

  // Only trst resets the sequencer so an in-flight access always drains its response.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_state      <= ST_IDLE;
      r_req_valid  <= 1'b0;
      r_req_op     <= DTM_NOP;
      r_resp_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_dr_op == DTM_READ) begin
            r_state     <= ST_READ;
            r_req_valid <= 1'b1;
            r_req_op    <= DTM_READ;
          end else if (w_accept && w_dr_op == DTM_WRITE) begin
            r_state     <= ST_WRITE;
            r_req_valid <= 1'b1;
            r_req_op    <= DTM_WRITE;
          end
        end
        ST_READ, ST_WRITE: begin
          if (dmi.req_ready) begin
            r_state      <= (r_state == ST_READ) ? ST_WAIT_READ : ST_WAIT_WRITE;
            r_req_valid  <= 1'b0;
            r_req_op     <= DTM_NOP;
            r_resp_ready <= 1'b1;
          end
        end
        ST_WAIT_READ, ST_WAIT_WRITE: begin
          if (dmi.resp_valid) begin
            r_state      <= ST_IDLE;
            r_resp_ready <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_req_valid  <= 1'b0;
          r_req_op     <= DTM_NOP;
          r_resp_ready <= 1'b0;
        end
      endcase
    end
  end

  assign dmi_tdo_o      = r_dr[0];
  assign dmi_error_o    = r_error;
  assign dmi.req_valid  = r_req_valid;
  assign dmi.req_op     = r_req_op;
  assign dmi.req_addr   = r_addr;
  assign dmi.req_data   = r_data;
  assign dmi.resp_ready = r_resp_ready;

endmodule

// File: tb/tb_dmi_jtag_access_ctrl.sv
// tb/tb_dmi_jtag_access_ctrl.sv - directed/random bench for the DMI access controller
module tb_dmi_jtag_access_ctrl;

  localparam int AW  = 7;
  localparam int DW  = 32;
  localparam int DRW = AW + DW + 2;

  logic tck = 1'b0;
  logic trst_n = 1'b0;
  logic tlr = 1'b0;
  logic access = 1'b0;
  logic cap = 1'b0;
  logic sh = 1'b0;
  logic upd = 1'b0;
  logic dmirst = 1'b0;
  logic tdi = 1'b0;
  logic tdo;
  logic [1:0] err;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: the three user-visible registers plus the last word shifted in.
  logic [AW-1:0]  m_addr = '0;
  logic [DW-1:0]  m_data = '0;
  logic [1:0]     m_err = 2'd0;
  logic [DRW-1:0] m_dr = '0;

  logic [DRW-1:0] din, dout;
  logic [AW-1:0]  a;
  logic [DW-1:0]  d, rd;

  dmi_jtag_access_ctrl_if #(.AddrWidth(AW), .DataWidth(DW)) dmi ();

  dmi_jtag_access_ctrl #(.AddrWidth(AW), .DataWidth(DW)) dut (
    .tck_i              (tck),
    .trst_ni            (trst_n),
    .test_logic_reset_i (tlr),
    .dmi_access_i       (access),
    .capture_dr_i       (cap),
    .shift_dr_i         (sh),
    .update_dr_i        (upd),
    .dmi_reset_i        (dmirst),
    .dmi_tdi_i          (tdi),
    .dmi_tdo_o          (tdo),
    .dmi_error_o        (err),
    .dmi                (dmi)
  );

  always #5 tck = ~tck;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scan(input logic [DRW-1:0] w, input bit do_cap, input bit do_upd,
                      output logic [DRW-1:0] o);
    if (do_cap) begin
      cap = 1'b1;
      @(negedge tck);
      cap = 1'b0;
    end
    sh = 1'b1;
    for (int i = 0; i < DRW; i++) begin
      o[i] = tdo;
      tdi  = w[i];
      @(negedge tck);
    end
    sh = 1'b0;
    if (do_upd) begin
      upd = 1'b1;
      @(negedge tck);
      upd = 1'b0;
    end
  endtask

  function automatic logic [DRW-1:0] cap_word();
    return {m_addr, m_data, m_err};
  endfunction

  task automatic pulse_dmireset();
    dmirst = 1'b1;
    @(negedge tck);
    dmirst = 1'b0;
    m_err = 2'd0;
  endtask

  initial begin
    dmi.req_ready  = 1'b0;
    dmi.resp_valid = 1'b0;
    dmi.resp_data  = '0;
    dmi.resp_err   = 1'b0;

    #1;
    check("reset_outputs", {tdo, err, dmi.req_valid, dmi.req_op, dmi.resp_ready}, '0);
    check("reset_addr_data", {dmi.req_addr, dmi.req_data}, '0);
    @(negedge tck);
    trst_n = 1'b1;
    access = 1'b1;
    @(negedge tck);

    // Reads with ready held high and response present: completes 3 edges after update.
    dmi.req_ready  = 1'b1;
    dmi.resp_valid = 1'b1;
    for (int it = 0; it < 3; it++) begin
      a  = (it == 0) ? 7'h11 : 7'($urandom);
      rd = (it == 0) ? 32'hDEADBEEF : $urandom;
      dmi.resp_data = rd;
      din = {a, 32'($urandom), 2'd1};
      scan(din, 1'b1, 1'b1, dout);
      check("read_scan_capture", dout, cap_word());
      m_dr = din;
      check("read_req", {dmi.req_valid, dmi.req_op, dmi.req_addr}, {1'b1, 2'd1, a});
      @(negedge tck);
      check("read_wait", {dmi.req_valid, dmi.resp_ready}, 2'b01);
      @(negedge tck);
      check("read_idle", {dmi.req_valid, dmi.resp_ready}, 2'b00);
      m_addr = a;
      m_data = rd;
      din = {7'($urandom), 32'($urandom), 2'd0};
      scan(din, 1'b1, 1'b1, dout);
      check("read_result_scan", dout, cap_word());
      m_dr = din;
    end

    // Write held stable while ready is low.
    dmi.req_ready  = 1'b0;
    dmi.resp_valid = 1'b0;
    din = {7'h04, 32'h80000001, 2'd2};
    scan(din, 1'b1, 1'b1, dout);
    check("write_scan_capture", dout, cap_word());
    m_dr = din;
    for (int c = 0; c < 5; c++) begin
      check("write_hold", {dmi.req_valid, dmi.req_op, dmi.req_addr, dmi.req_data},
            {1'b1, 2'd2, 7'h04, 32'h80000001});
      @(negedge tck);
    end
    dmi.req_ready = 1'b1;
    @(negedge tck);
    dmi.req_ready = 1'b0;
    check("write_resp_ready", {dmi.req_valid, dmi.resp_ready}, 2'b01);
    m_addr = 7'h04;
    m_data = 32'h80000001;

    // Busy: scan while the write response is outstanding.
    din = {7'($urandom), 32'($urandom), 2'd1};
    scan(din, 1'b1, 1'b1, dout);
    if (m_err == 2'd0) m_err = 2'd3;
    check("busy_capture", dout, cap_word());
    m_dr = din;
    check("busy_err", {err, dmi.req_valid}, {2'd3, 1'b0});
    dmi.resp_valid = 1'b1;
    @(negedge tck);
    dmi.resp_valid = 1'b0;
    check("busy_drain", {dmi.req_valid, dmi.resp_ready}, 2'b00);
    din = {7'($urandom), 32'($urandom), 2'd0};
    scan(din, 1'b1, 1'b1, dout);
    check("busy_sticky_scan", dout, cap_word());
    m_dr = din;
    pulse_dmireset();
    check("busy_cleared", err, m_err);

    // Op failure blocks later requests until dmireset.
    a = 7'($urandom);
    d = $urandom;
    dmi.req_ready  = 1'b1;
    dmi.resp_valid = 1'b1;
    dmi.resp_err   = 1'b1;
    din = {a, d, 2'd2};
    scan(din, 1'b1, 1'b1, dout);
    check("fail_scan_capture", dout, cap_word());
    m_dr = din;
    @(negedge tck);
    @(negedge tck);
    check("fail_err", {err, dmi.req_valid, dmi.resp_ready}, {2'd2, 2'b00});
    dmi.resp_err = 1'b0;
    m_addr = a;
    m_data = d;
    m_err  = 2'd2;
    a  = 7'($urandom);
    rd = $urandom;
    dmi.resp_data = rd;
    din = {a, 32'($urandom), 2'd1};
    scan(din, 1'b1, 1'b1, dout);
    check("fail_sticky_scan", dout, cap_word());
    m_dr = din;
    for (int c = 0; c < 3; c++) begin
      check("fail_discard", {dmi.req_valid, dmi.resp_ready}, 2'b00);
      @(negedge tck);
    end
    pulse_dmireset();
    check("fail_cleared", err, m_err);
    scan(din, 1'b1, 1'b1, dout);
    check("post_reset_scan", dout, cap_word());
    check("post_reset_req", {dmi.req_valid, dmi.req_addr}, {1'b1, a});
    @(negedge tck);
    @(negedge tck);
    m_addr = a;
    m_data = rd;

    // Gated: nothing moves while DMIACCESS is not selected.
    access = 1'b0;
    din = {7'($urandom), 32'($urandom), 2'd1};
    scan(din, 1'b1, 1'b1, dout);
    check("gated_tdo", tdo, m_dr[0]);
    check("gated_no_req", {dmi.req_valid, dmi.resp_ready}, 2'b00);
    access = 1'b1;
    din = {7'($urandom), 32'($urandom), 2'd0};
    scan(din, 1'b0, 1'b0, dout);
    check("gated_dr_kept", dout, m_dr);
    m_dr = din;

    // TLR mid-read clears registers but the response still drains.
    dmi.resp_valid = 1'b0;
    a = 7'($urandom);
    din = {a, 32'($urandom), 2'd1};
    scan(din, 1'b1, 1'b1, dout);
    check("tlr_scan_capture", dout, cap_word());
    @(negedge tck);
    check("tlr_in_wait", dmi.resp_ready, 1'b1);
    tlr = 1'b1;
    @(negedge tck);
    tlr = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_err  = 2'd0;
    m_dr   = '0;
    check("tlr_cleared", {err, tdo, dmi.resp_ready}, {2'd0, 1'b0, 1'b1});
    din = {7'($urandom), 32'($urandom), 2'd0};
    scan(din, 1'b0, 1'b0, dout);
    check("tlr_dr_zero", dout, m_dr);
    m_dr = din;
    check("tlr_still_waiting", dmi.resp_ready, 1'b1);
    rd = $urandom;
    dmi.resp_data  = rd;
    dmi.resp_valid = 1'b1;
    @(negedge tck);
    dmi.resp_valid = 1'b0;
    check("tlr_drained", dmi.resp_ready, 1'b0);
    m_data = rd;
    din = {7'($urandom), 32'($urandom), 2'd0};
    scan(din, 1'b1, 1'b1, dout);
    check("tlr_drain_scan", dout, cap_word());

    // Async trst in the middle of a request.
    dmi.req_ready = 1'b0;
    din = {7'($urandom), 32'($urandom), 2'd1};
    scan(din, 1'b1, 1'b1, dout);
    check("trst_pre_req", dmi.req_valid, 1'b1);
    #2;
    trst_n = 1'b0;
    #1;
    check("trst_async", {tdo, err, dmi.req_valid, dmi.req_op, dmi.resp_ready, dmi.req_addr, dmi.req_data}, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
